// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX stage: the decoder control bundle, the
// all-zero bubble constant and the operand-use rules of the decoder encoding.
package id_ex_pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [1:0] alu_1_src;
        logic       alu_2_src;
        logic       reg_write;
        logic       is_branch;
        logic       is_jalr;
        logic       is_jal;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_width;
        logic       mem_sign_extend;
        logic [1:0] reg_src;
        logic [3:0] alu_op;
        logic       alu_flag;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // rs1 is read unless operand 1 comes from PC/zero, or the instruction is JAL
    function automatic logic uses_rs1(input ctrl_t c);
        return (c.alu_1_src == 2'b00) & ~c.is_jal;
    endfunction

    // rs2 is read as ALU operand, as store data, or as branch comparand
    function automatic logic uses_rs2(input ctrl_t c);
        return ~c.alu_2_src | c.mem_write | c.is_branch;
    endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detector for the ID/EX stage (purely combinational).
// Ports:
//   id_valid, id_ctrl, id_rs1, id_rs2 : instruction currently in ID
//   ex_valid, ex_mem_read, ex_rd      : instruction currently in EX
//   flush, stall_in                   : EX redirect and MEM busy
//   hz                                : ID reads the register a load in EX writes
//   stall_out                         : hold PC and IF/ID
module id_ex_pipe_hazard_detect
    import id_ex_pipe_pkg::*;
(
    input  logic                 id_valid,
    input  ctrl_t                id_ctrl,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 flush,
    input  logic                 stall_in,
    output logic                 hz,
    output logic                 stall_out
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = uses_rs1(id_ctrl) & (ex_rd == id_rs1);
    assign rs2_match = uses_rs2(id_ctrl) & (ex_rd == id_rs2);

    // x0 is never written, so a load targeting it cannot create a dependency
    assign hz = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid & (rs1_match | rs2_match);

    // a flush kills the ID instruction, so there is nothing to hold upstream
    assign stall_out = stall_in | (hz & ~flush);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush and MEM stall.
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_*_i      : decoded instruction, operands and control bundle from ID
//   flush_i     : taken branch/jump resolved in EX, kill the ID instruction
//   stall_i     : MEM busy, freeze this stage
//   stall_o     : hold PC and IF/ID (combinational)
//   ex_*_o      : registered copy of the id_* inputs, all zero for a bubble
//   bubble_cnt_o: saturating count of bubbles inserted by flush or hazard
module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [1:0]       id_alu_1_src_i,
    input  logic             id_alu_2_src_i,
    input  logic             id_reg_write_i,
    input  logic             id_is_branch_i,
    input  logic             id_is_jalr_i,
    input  logic             id_is_jal_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic [1:0]       id_mem_width_i,
    input  logic             id_mem_sign_extend_i,
    input  logic [1:0]       id_reg_src_i,
    input  logic [3:0]       id_alu_op_i,
    input  logic             id_alu_flag_i,
    input  logic             flush_i,
    input  logic             stall_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [1:0]       ex_alu_1_src_o,
    output logic             ex_alu_2_src_o,
    output logic             ex_reg_write_o,
    output logic             ex_is_branch_o,
    output logic             ex_is_jalr_o,
    output logic             ex_is_jal_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o,
    output logic [1:0]       ex_mem_width_o,
    output logic             ex_mem_sign_extend_o,
    output logic [1:0]       ex_reg_src_o,
    output logic [3:0]       ex_alu_op_o,
    output logic             ex_alu_flag_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    import id_ex_pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t            id_ctrl;
    ctrl_t            ex_ctrl;
    logic             hz;
    logic             load_bubble;
    logic             count_bubble;
    logic [CNT_W-1:0] bubble_cnt;

    assign id_ctrl = '{
        alu_1_src:       id_alu_1_src_i,
        alu_2_src:       id_alu_2_src_i,
        reg_write:       id_reg_write_i,
        is_branch:       id_is_branch_i,
        is_jalr:         id_is_jalr_i,
        is_jal:          id_is_jal_i,
        mem_read:        id_mem_read_i,
        mem_write:       id_mem_write_i,
        mem_width:       id_mem_width_i,
        mem_sign_extend: id_mem_sign_extend_i,
        reg_src:         id_reg_src_i,
        alu_op:          id_alu_op_i,
        alu_flag:        id_alu_flag_i
    };

    id_ex_pipe_hazard_detect u_hazard (
        .id_valid    (id_valid_i),
        .id_ctrl     (id_ctrl),
        .id_rs1      (id_rs1_i),
        .id_rs2      (id_rs2_i),
        .ex_valid    (ex_valid_o),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd_o),
        .flush       (flush_i),
        .stall_in    (stall_i),
        .hz          (hz),
        .stall_out   (stall_o)
    );

    // an empty ID slot also becomes a bubble, but only flush/hazard bubbles are counted
    assign load_bubble  = flush_i | hz | ~id_valid_i;
    assign count_bubble = ~stall_i & (flush_i | hz);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_ctrl       <= BUBBLE_CTRL;
        end else if (!stall_i) begin
            if (load_bubble) begin
                ex_valid_o    <= 1'b0;
                ex_pc_o       <= '0;
                ex_rs1_o      <= '0;
                ex_rs2_o      <= '0;
                ex_rd_o       <= '0;
                ex_rs1_data_o <= '0;
                ex_rs2_data_o <= '0;
                ex_imm_o      <= '0;
                ex_ctrl       <= BUBBLE_CTRL;
            end else begin
                ex_valid_o    <= 1'b1;
                ex_pc_o       <= id_pc_i;
                ex_rs1_o      <= id_rs1_i;
                ex_rs2_o      <= id_rs2_i;
                ex_rd_o       <= id_rd_i;
                ex_rs1_data_o <= id_rs1_data_i;
                ex_rs2_data_o <= id_rs2_data_i;
                ex_imm_o      <= id_imm_i;
                ex_ctrl       <= id_ctrl;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt <= '0;
        end else if (count_bubble && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

    assign bubble_cnt_o         = bubble_cnt;
    assign ex_alu_1_src_o       = ex_ctrl.alu_1_src;
    assign ex_alu_2_src_o       = ex_ctrl.alu_2_src;
    assign ex_reg_write_o       = ex_ctrl.reg_write;
    assign ex_is_branch_o       = ex_ctrl.is_branch;
    assign ex_is_jalr_o         = ex_ctrl.is_jalr;
    assign ex_is_jal_o          = ex_ctrl.is_jal;
    assign ex_mem_read_o        = ex_ctrl.mem_read;
    assign ex_mem_write_o       = ex_ctrl.mem_write;
    assign ex_mem_width_o       = ex_ctrl.mem_width;
    assign ex_mem_sign_extend_o = ex_ctrl.mem_sign_extend;
    assign ex_reg_src_o         = ex_ctrl.reg_src;
    assign ex_alu_op_o          = ex_ctrl.alu_op;
    assign ex_alu_flag_o        = ex_ctrl.alu_flag;

endmodule
